// File: rtl/stepper_xy_move_splitter.sv
// stepper_xy_move_splitter
//
// Command front-end for the XY stepper path. Takes one signed relative move
// (dx, dy) that may exceed the per-transaction pulse range of the XY stepper
// interface. It cuts the move into saturated chunks, one XY transaction each,
// and pulses cmd_done once the whole move has been issued and completed.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   cmd_valid        move request, sampled only while cmd_rdy=1
//   cmd_dx, cmd_dy   signed move in steps (MOVE_BITS)
//   cmd_pulse_width  pulse width forwarded on every chunk
//   cmd_rdy          high only in IDLE
//   cmd_done         one-cycle pulse at end of the whole move
//   xy_pulse_num_x/y signed per-chunk counts, held from CHUNK to end of WAIT
//   xy_pulse_width   latched cmd_pulse_width
//   xy_trigger       one-cycle start pulse for the current chunk
//   xy_rdy           XY controller idle / able to accept a trigger
//   xy_done          XY controller finished its last transaction
//
// State table
//   state  | meaning
//   IDLE   | waiting for a command, cmd_rdy=1
//   CHUNK  | compute next saturated chunk, or finish when nothing remains
//   ISSUE  | fire xy_trigger in the first cycle xy_rdy=1
//   ARM    | wait for xy_rdy to drop (trigger accepted); xy_done ignored
//   WAIT   | wait for xy_done=1 with xy_rdy=1
//   DONE   | one-cycle cmd_done

module stepper_xy_move_splitter #(
  parameter int PULSE_NUM_BITS   = 16,
  parameter int PULSE_WIDTH_BITS = 16,
  parameter int MOVE_BITS        = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [MOVE_BITS-1:0]        cmd_dx,
  input  logic [MOVE_BITS-1:0]        cmd_dy,
  input  logic [PULSE_WIDTH_BITS-1:0] cmd_pulse_width,
  output logic                        cmd_rdy,
  output logic                        cmd_done,
  output logic [PULSE_NUM_BITS-1:0]   xy_pulse_num_x,
  output logic [PULSE_NUM_BITS-1:0]   xy_pulse_num_y,
  output logic [PULSE_WIDTH_BITS-1:0] xy_pulse_width,
  output logic                        xy_trigger,
  input  logic                        xy_rdy,
  input  logic                        xy_done
);

  // Chunk magnitude limit; the most negative code is never emitted so both
  // directions have the same reach.
  localparam logic signed [MOVE_BITS-1:0] M_POS =
    MOVE_BITS'((64'sd1 <<< (PULSE_NUM_BITS - 1)) - 64'sd1);
  localparam logic signed [MOVE_BITS-1:0] M_NEG = -M_POS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHUNK = 3'd1,
    S_ISSUE = 3'd2,
    S_ARM   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic signed [MOVE_BITS-1:0] rem_x, rem_y;
  logic signed [MOVE_BITS-1:0] ext_x, ext_y;
  logic                        rem_zero;

  function automatic logic [PULSE_NUM_BITS-1:0] sat(
    input logic signed [MOVE_BITS-1:0] v
  );
    logic signed [MOVE_BITS-1:0] r;
    if (v > M_POS)      r = M_POS;
    else if (v < M_NEG) r = M_NEG;
    else                r = v;
    return r[PULSE_NUM_BITS-1:0];
  endfunction

  // Sign-extended current chunk, subtracted from the remainder on trigger.
  // Same sign and |chunk| <= |rem|, so the subtraction cannot overflow.
  assign ext_x    = MOVE_BITS'($signed(xy_pulse_num_x));
  assign ext_y    = MOVE_BITS'($signed(xy_pulse_num_y));
  assign rem_zero = (rem_x == '0) && (rem_y == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_rdy    = 1'b0;
    cmd_done   = 1'b0;
    xy_trigger = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_valid) state_next = S_CHUNK;
      end
      S_CHUNK: begin
        if (rem_zero) state_next = S_DONE;
        else          state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // Qualified by xy_rdy so the trigger lands in the first ready cycle.
        if (xy_rdy) begin
          xy_trigger = 1'b1;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (!xy_rdy) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (xy_done && xy_rdy) state_next = S_CHUNK;
      end
      S_DONE: begin
        cmd_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_x          <= '0;
      rem_y          <= '0;
      xy_pulse_num_x <= '0;
      xy_pulse_num_y <= '0;
      xy_pulse_width <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rem_x          <= cmd_dx;
            rem_y          <= cmd_dy;
            xy_pulse_width <= cmd_pulse_width;
          end
        end
        S_CHUNK: begin
          if (!rem_zero) begin
            xy_pulse_num_x <= sat(rem_x);
            xy_pulse_num_y <= sat(rem_y);
          end
        end
        S_ISSUE: begin
          if (xy_rdy) begin
            rem_x <= rem_x - ext_x;
            rem_y <= rem_y - ext_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_xy_move_splitter.sv
module tb_stepper_xy_move_splitter;

  localparam int PNB = 8;
  localparam int PWB = 16;
  localparam int MB  = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic [MB-1:0]  cmd_dx, cmd_dy;
  logic [PWB-1:0] cmd_pulse_width;
  logic           cmd_rdy, cmd_done;
  logic [PNB-1:0] xy_pulse_num_x, xy_pulse_num_y;
  logic [PWB-1:0] xy_pulse_width;
  logic           xy_trigger;
  logic           xy_rdy, xy_done;

  int checks = 0;
  int errors = 0;

  // Results of the most recent do_move
  int tx[8], ty[8], tpw[8], tk[8];
  int n_trig, n_done, done_k;
  bit rdy_at0, rdy_at1, rdy_after, viol, timed_out;

  stepper_xy_move_splitter #(
    .PULSE_NUM_BITS(PNB), .PULSE_WIDTH_BITS(PWB), .MOVE_BITS(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_dx(cmd_dx), .cmd_dy(cmd_dy),
    .cmd_pulse_width(cmd_pulse_width),
    .cmd_rdy(cmd_rdy), .cmd_done(cmd_done),
    .xy_pulse_num_x(xy_pulse_num_x), .xy_pulse_num_y(xy_pulse_num_y),
    .xy_pulse_width(xy_pulse_width), .xy_trigger(xy_trigger),
    .xy_rdy(xy_rdy), .xy_done(xy_done)
  );

  always #5 clk = ~clk;

  // Drives one move and plays the XY controller: after each trigger xy_rdy is
  // low for 3 cycles, then xy_rdy=1/xy_done=1 (WAIT exit at trigger+4).
  // Cycle k=0 is the cmd_valid acceptance cycle; inputs are driven 1 ns after
  // the rising edge, outputs sampled on the falling edge.
  task automatic do_move(input int dx, input int dy, input int pw,
                         input int hold, input bit stale);
    logic [31:0] vdx, vdy, vpw;
    bit prev_trig;
    int last_tk;
    vdx = dx; vdy = dy; vpw = pw;
    n_trig = 0; n_done = 0; done_k = -1; viol = 0; timed_out = 1;
    rdy_at0 = 0; rdy_at1 = 1; rdy_after = 0; prev_trig = 0; last_tk = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        cmd_valid = 1'b1; cmd_dx = vdx[MB-1:0]; cmd_dy = vdy[MB-1:0];
        cmd_pulse_width = vpw[PWB-1:0];
      end else if (k == 4) begin
        cmd_valid = 1'b1; cmd_dx = 24'd7; cmd_dy = 24'd7; cmd_pulse_width = 16'd99;
      end else begin
        cmd_valid = 1'b0;
      end
      if (n_trig == 0) begin
        xy_rdy = (k >= 2 + hold); xy_done = stale;
      end else if (k < last_tk + 4) begin
        xy_rdy = 1'b0; xy_done = stale;
      end else begin
        xy_rdy = 1'b1; xy_done = 1'b1;
      end
      @(negedge clk);
      if (k == 0) rdy_at0 = cmd_rdy;
      if (k == 1) rdy_at1 = cmd_rdy;
      if (xy_trigger) begin
        if (!xy_rdy || prev_trig) viol = 1;
        if (n_trig < 8) begin
          tx[n_trig]  = int'($signed(xy_pulse_num_x));
          ty[n_trig]  = int'($signed(xy_pulse_num_y));
          tpw[n_trig] = int'(xy_pulse_width);
          tk[n_trig]  = k;
        end
        last_tk = k;
        n_trig++;
      end
      prev_trig = xy_trigger;
      if (cmd_done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        rdy_after = cmd_rdy; timed_out = 0;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 0; cmd_dx = 0; cmd_dy = 0; cmd_pulse_width = 0;
    xy_rdy = 1'b1; xy_done = 1'b1;
    #12;
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_cmd_rdy got %b want 1", cmd_rdy); end
    checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_cmd_done got %b want 0", cmd_done); end
    checks++; if (xy_trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger got %b want 0", xy_trigger); end
    checks++; if ({xy_pulse_num_x, xy_pulse_num_y, xy_pulse_width} !== 32'h0) begin
      errors++; $display("FAIL reset_chunk got %h %h %h want 0", xy_pulse_num_x, xy_pulse_num_y, xy_pulse_width);
    end
    @(negedge clk); reset = 1'b0; xy_rdy = 1'b0; xy_done = 1'b0;
  endtask

  task automatic test_single_chunk();
    do_move(100, -50, 20, 0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL single_timeout got timeout want done"); end
    checks++; if (rdy_at0 !== 1'b1 || rdy_at1 !== 1'b0) begin errors++; $display("FAIL single_cmd_rdy got %b%b want 10", rdy_at0, rdy_at1); end
    checks++; if (n_trig !== 1) begin errors++; $display("FAIL single_ntrig got %0d want 1", n_trig); end
    checks++; if (tx[0] !== 100 || ty[0] !== -50 || tpw[0] !== 20) begin
      errors++; $display("FAIL single_chunk got %0d,%0d,%0d want 100,-50,20", tx[0], ty[0], tpw[0]);
    end
    checks++; if (tk[0] !== 2) begin errors++; $display("FAIL single_trig_time got %0d want 2", tk[0]); end
    checks++; if (done_k !== 8) begin errors++; $display("FAIL single_done_time got %0d want 8", done_k); end
    checks++; if (n_done !== 1 || rdy_after !== 1'b1) begin errors++; $display("FAIL single_done_rdy got %0d %b want 1 1", n_done, rdy_after); end
  endtask

  task automatic test_multi_chunk_x();
    do_move(300, 0, 7, 0, 0);
    checks++; if (n_trig !== 3) begin errors++; $display("FAIL x300_ntrig got %0d want 3", n_trig); end
    checks++; if (tx[0] !== 127 || tx[1] !== 127 || tx[2] !== 46) begin
      errors++; $display("FAIL x300_chunks got %0d,%0d,%0d want 127,127,46", tx[0], tx[1], tx[2]);
    end
    checks++; if (ty[0] !== 0 || ty[1] !== 0 || ty[2] !== 0 || tpw[2] !== 7) begin
      errors++; $display("FAIL x300_y_pw got %0d,%0d,%0d pw %0d want 0,0,0 pw 7", ty[0], ty[1], ty[2], tpw[2]);
    end
    checks++; if (tk[1] !== 8 || tk[2] !== 14) begin errors++; $display("FAIL x300_trig_times got %0d,%0d want 8,14", tk[1], tk[2]); end
    checks++; if (done_k !== 20 || n_done !== 1) begin errors++; $display("FAIL x300_done got %0d x%0d want 20 x1", done_k, n_done); end
    checks++; if (viol) begin errors++; $display("FAIL x300_trigger_rules got violation want none"); end
  endtask

  task automatic test_multi_chunk_xy();
    do_move(-200, 130, 33, 0, 0);
    checks++; if (n_trig !== 2) begin errors++; $display("FAIL xy_ntrig got %0d want 2", n_trig); end
    checks++; if (tx[0] !== -127 || ty[0] !== 127) begin errors++; $display("FAIL xy_chunk0 got %0d,%0d want -127,127", tx[0], ty[0]); end
    checks++; if (tx[1] !== -73 || ty[1] !== 3) begin errors++; $display("FAIL xy_chunk1 got %0d,%0d want -73,3", tx[1], ty[1]); end
    checks++; if (done_k !== 14) begin errors++; $display("FAIL xy_done_time got %0d want 14", done_k); end
  endtask

  task automatic test_zero_move();
    do_move(0, 0, 5, 0, 0);
    checks++; if (n_trig !== 0) begin errors++; $display("FAIL zero_ntrig got %0d want 0", n_trig); end
    checks++; if (done_k !== 2) begin errors++; $display("FAIL zero_done_time got %0d want 2", done_k); end
    checks++; if (rdy_after !== 1'b1 || rdy_at1 !== 1'b0) begin errors++; $display("FAIL zero_cmd_rdy got %b%b want 01", rdy_at1, rdy_after); end
  endtask

  task automatic test_rdy_hold_stale_done();
    do_move(10, -10, 3, 10, 1);
    checks++; if (n_trig !== 1 || tk[0] !== 12) begin errors++; $display("FAIL hold_trig got n%0d at %0d want n1 at 12", n_trig, tk[0]); end
    checks++; if (tx[0] !== 10 || ty[0] !== -10) begin errors++; $display("FAIL hold_chunk got %0d,%0d want 10,-10", tx[0], ty[0]); end
    checks++; if (done_k !== 18 || n_done !== 1) begin errors++; $display("FAIL hold_done got %0d x%0d want 18 x1", done_k, n_done); end
    checks++; if (viol) begin errors++; $display("FAIL hold_trigger_rules got violation want none"); end
  endtask

  task automatic test_reset_mid_move();
    int ntr, late;
    ntr = 0; late = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin cmd_valid = 1'b1; cmd_dx = 24'd300; cmd_dy = 24'd0; cmd_pulse_width = 16'd9; end
      else cmd_valid = 1'b0;
      xy_done = 1'b0;
      xy_rdy  = (k == 2);
      @(negedge clk);
      if (xy_trigger) ntr++;
    end
    checks++; if (ntr !== 1) begin errors++; $display("FAIL rstmid_first_trig got %0d want 1", ntr); end
    reset = 1'b1; xy_rdy = 1'b1; xy_done = 1'b1;
    #1;
    checks++; if (cmd_rdy !== 1'b1 || cmd_done !== 1'b0 || xy_trigger !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got rdy%b done%b trig%b want 1 0 0", cmd_rdy, cmd_done, xy_trigger);
    end
    checks++; if ({xy_pulse_num_x, xy_pulse_num_y, xy_pulse_width} !== 32'h0) begin
      errors++; $display("FAIL rstmid_chunk got %h %h %h want 0", xy_pulse_num_x, xy_pulse_num_y, xy_pulse_width);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (xy_trigger) late++;
    end
    checks++; if (late !== 0) begin errors++; $display("FAIL rstmid_no_trigger got %0d want 0", late); end
    do_move(5, 0, 11, 0, 0);
    checks++; if (n_trig !== 1 || tx[0] !== 5 || ty[0] !== 0 || tpw[0] !== 11) begin
      errors++; $display("FAIL rstmid_followup got n%0d %0d,%0d,%0d want n1 5,0,11", n_trig, tx[0], ty[0], tpw[0]);
    end
    checks++; if (done_k !== 8) begin errors++; $display("FAIL rstmid_followup_done got %0d want 8", done_k); end
  endtask

  initial begin
    test_reset();
    test_single_chunk();
    test_multi_chunk_x();
    test_multi_chunk_xy();
    test_zero_move();
    test_rdy_hold_stale_done();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
